// File: rtl/fir_mac_filter.sv
// Time-multiplexed signed FIR filter: one shared MAC walks a circular delay line
// against run-time loadable coefficients. The output is rounded, scaled and saturated.
module fir_mac_filter #(
  parameter int ORDER    = 8,
  parameter int SAMPLE_W = 24,
  parameter int COEF_W   = 16,
  parameter int OUT_W    = 24,
  parameter int SHIFT    = 15,
  localparam int AW      = (ORDER > 1) ? $clog2(ORDER) : 1,
  localparam int ACC_W   = SAMPLE_W + COEF_W + $clog2(ORDER)
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic signed [SAMPLE_W-1:0] i_sample,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic                       i_coef_we,
  input  logic [AW-1:0]              i_coef_addr,
  input  logic signed [COEF_W-1:0]   i_coef_data,
  output logic signed [OUT_W-1:0]    o_result,
  output logic                       o_valid,
  output logic                       o_sat
);

  localparam int PROD_W = SAMPLE_W + COEF_W;
  localparam logic [AW-1:0] LAST_TAP = AW'(ORDER - 1);
  localparam logic [AW:0]   ORDER_C  = (AW+1)'(ORDER);
  localparam logic [ACC_W:0] ONE     = {{ACC_W{1'b0}}, 1'b1};
  // Half an output LSB; collapses to zero when SHIFT is 0.
  localparam logic signed [ACC_W:0] RND = (ONE << SHIFT) >> 1;
  localparam logic signed [ACC_W:0] OUT_MAX = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] OUT_MIN = {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                     state_reg;
  logic signed [SAMPLE_W-1:0] delay_reg [ORDER];
  logic signed [COEF_W-1:0]   coef_reg  [ORDER];
  logic [AW-1:0]              head_reg;
  logic [AW-1:0]              rd_ptr_reg;
  logic [AW-1:0]              tap_reg;
  logic signed [ACC_W-1:0]    acc_reg;

  logic                       accept;
  logic                       coef_wr;
  logic signed [SAMPLE_W-1:0] x_cur;
  logic signed [COEF_W-1:0]   h_cur;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W:0]      rnd_sum;
  logic signed [ACC_W:0]      shifted;
  logic signed [OUT_W-1:0]    result_next;
  logic                       sat_next;

  assign accept  = (state_reg == IDLE) && i_valid;
  assign coef_wr = (state_reg == IDLE) && i_coef_we && ({1'b0, i_coef_addr} < ORDER_C);

  // Per-entry storage so every tap has exactly one writer and its own reset.
  for (genvar gi = 0; gi < ORDER; gi++) begin : g_tap
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        delay_reg[gi] <= '0;
      end else if (accept && (head_reg == AW'(gi))) begin
        delay_reg[gi] <= i_sample;
      end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        coef_reg[gi] <= '0;
      end else if (coef_wr && (i_coef_addr == AW'(gi))) begin
        coef_reg[gi] <= i_coef_data;
      end
    end
  end

  assign x_cur    = delay_reg[rd_ptr_reg];
  assign h_cur    = coef_reg[tap_reg];
  assign prod     = x_cur * h_cur;
  assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

  // One guard bit above the accumulator keeps the rounding add from wrapping.
  assign rnd_sum = {acc_reg[ACC_W-1], acc_reg} + RND;
  assign shifted = rnd_sum >>> SHIFT;

  always_comb begin
    sat_next    = 1'b0;
    result_next = shifted[OUT_W-1:0];
    if (shifted > OUT_MAX) begin
      sat_next    = 1'b1;
      result_next = OUT_MAX[OUT_W-1:0];
    end else if (shifted < OUT_MIN) begin
      sat_next    = 1'b1;
      result_next = OUT_MIN[OUT_W-1:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg  <= IDLE;
      o_ready    <= 1'b1;
      o_result   <= '0;
      o_valid    <= 1'b0;
      o_sat      <= 1'b0;
      acc_reg    <= '0;
      head_reg   <= '0;
      rd_ptr_reg <= '0;
      tap_reg    <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_valid) begin
            acc_reg    <= '0;
            tap_reg    <= '0;
            rd_ptr_reg <= head_reg;
            o_ready    <= 1'b0;
            state_reg  <= MAC;
          end
        end
        MAC: begin
          acc_reg    <= acc_reg + prod_ext;
          // Walk backwards in time: x[n-k] sits at (head - k) mod ORDER.
          rd_ptr_reg <= (rd_ptr_reg == '0) ? LAST_TAP : rd_ptr_reg - 1'b1;
          if (tap_reg == LAST_TAP) begin
            head_reg  <= (head_reg == LAST_TAP) ? '0 : head_reg + 1'b1;
            state_reg <= OUT;
          end else begin
            tap_reg <= tap_reg + 1'b1;
          end
        end
        OUT: begin
          o_result  <= result_next;
          o_sat     <= sat_next;
          o_valid   <= 1'b1;
          o_ready   <= 1'b1;
          state_reg <= IDLE;
        end
        default: begin
          o_ready   <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_filter.sv
// Directed bench for fir_mac_filter: three instances (ORDER=8/SHIFT=0, defaults,
// ORDER=5/SHIFT=0) share stimulus buses, with valid and write-enable steered by sel.
module tb_fir_mac_filter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [23:0] sample = '0;
  logic               valid = 1'b0;
  logic               we = 1'b0;
  logic [2:0]         addr = '0;
  logic signed [15:0] data = '0;
  int                 sel = 0;

  logic               ready_a, val_a, sat_a, ready_b, val_b, sat_b, ready_c, val_c, sat_c;
  logic signed [23:0] res_a, res_b, res_c;
  logic               cur_ready, cur_valid, cur_sat;
  logic signed [23:0] cur_res;

  int n_assert = 0;
  int n_fail = 0;

  fir_mac_filter #(.ORDER(8), .SHIFT(0)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_sample(sample), .i_valid(valid && sel == 0), .o_ready(ready_a),
    .i_coef_we(we && sel == 0), .i_coef_addr(addr), .i_coef_data(data),
    .o_result(res_a), .o_valid(val_a), .o_sat(sat_a));

  fir_mac_filter dut_b (
    .i_clk(clk), .i_rst(rst), .i_sample(sample), .i_valid(valid && sel == 1), .o_ready(ready_b),
    .i_coef_we(we && sel == 1), .i_coef_addr(addr), .i_coef_data(data),
    .o_result(res_b), .o_valid(val_b), .o_sat(sat_b));

  fir_mac_filter #(.ORDER(5), .SHIFT(0)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_sample(sample), .i_valid(valid && sel == 2), .o_ready(ready_c),
    .i_coef_we(we && sel == 2), .i_coef_addr(addr), .i_coef_data(data),
    .o_result(res_c), .o_valid(val_c), .o_sat(sat_c));

  always_comb begin
    cur_ready = ready_a; cur_valid = val_a; cur_sat = sat_a; cur_res = res_a;
    if (sel == 1) begin
      cur_ready = ready_b; cur_valid = val_b; cur_sat = sat_b; cur_res = res_b;
    end else if (sel == 2) begin
      cur_ready = ready_c; cur_valid = val_c; cur_sat = sat_c; cur_res = res_c;
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    @(negedge clk); we = 1'b1; addr = 3'(a); data = 16'(d);
    @(negedge clk); we = 1'b0;
  endtask

  // One sample through the selected DUT; optional same-edge write, optional pokes during MAC.
  task automatic run_sample(input int x, input bit same_we, input bit poke, input int wa, input int wd,
                            output int res, output int sat_o, output int lat);
    int guard;
    int t0;
    guard = 0;
    @(negedge clk);
    while (!cur_ready && guard < 100) begin @(negedge clk); guard++; end
    if (guard >= 100) check("ready_timeout", 0, 1);
    sample = 24'(x); valid = 1'b1;
    if (same_we) begin we = 1'b1; addr = 3'(wa); data = 16'(wd); end
    @(posedge clk); #1;
    t0 = cyc; valid = 1'b0; we = 1'b0;
    if (poke) begin
      @(negedge clk); valid = 1'b1; sample = 24'sd99; we = 1'b1; addr = 3'(wa); data = 16'(wd);
      @(negedge clk); valid = 1'b0; we = 1'b0;
    end
    guard = 0;
    do begin @(posedge clk); #1; guard++; end while (!cur_valid && guard < 100);
    if (guard >= 100) check("valid_timeout", 0, 1);
    lat = cyc - t0; res = int'(cur_res); sat_o = int'(cur_sat);
    $display("[%0t] dut%0d x=%0d result=%0d sat=%0d latency=%0d", $time, sel, x, res, sat_o, lat);
    @(posedge clk); #1;
    check("valid_pulse", longint'(cur_valid), 0);
  endtask

  task automatic samp(input string tag, input int x, input int exp_res, input int exp_sat, input int exp_lat);
    int r, s, l;
    run_sample(x, 1'b0, 1'b0, 0, 0, r, s, l);
    check({tag, "_result"}, r, exp_res);
    check({tag, "_sat"}, s, exp_sat);
    check({tag, "_latency"}, l, exp_lat);
  endtask

  initial begin
    int r, s, l, cnt, n, sum, guard;
    int t [4];
    int hist [$];

    do_reset();
    sel = 0;
    #1;
    check("rst_ready", cur_ready, 1);
    check("rst_valid", cur_valid, 0);
    check("rst_result", cur_res, 0);
    check("rst_sat", cur_sat, 0);

    // Impulse response of h[k]=k+1
    for (int k = 0; k < 8; k++) wr(k, k + 1);
    samp("imp0", 1, 1, 0, 9);
    for (int k = 1; k < 9; k++) samp($sformatf("imp%0d", k), 0, (k < 8) ? k + 1 : 0, 0, 9);

    // Ramp through a boxcar, exercises head wrap-around
    for (int k = 0; k < 8; k++) wr(k, 1);
    for (int v = 1; v <= 20; v++) begin
      hist.push_back(v);
      if (hist.size() > 8) void'(hist.pop_front());
      sum = 0;
      foreach (hist[i]) sum += hist[i];
      run_sample(v, 1'b0, 1'b0, 0, 0, r, s, l);
      check($sformatf("ramp%0d", v), r, sum);
    end

    // Continuous i_valid: accepts every ORDER+2 cycles
    @(negedge clk); sample = '0; valid = 1'b1; n = 0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (cur_ready && n < 4) begin t[n] = cyc + 1; n++; end
    end
    valid = 1'b0;
    check("held_accepts", longint'(n >= 3), 1);
    check("held_gap1", t[1] - t[0], 10);
    check("held_gap2", t[2] - t[1], 10);
    guard = 0;
    while (!cur_ready && guard < 50) begin @(negedge clk); guard++; end
    repeat (3) @(negedge clk);

    // Coefficient write timing rules
    do_reset();
    run_sample(2, 1'b0, 1'b1, 0, 5, r, s, l);
    check("mac_write_first", r, 0);
    run_sample(2, 1'b0, 1'b0, 0, 0, r, s, l);
    check("mac_write_ignored", r, 0);
    run_sample(2, 1'b1, 1'b0, 0, 5, r, s, l);
    check("same_edge_write", r, 10);
    wr(1, 1);
    run_sample(3, 1'b0, 1'b0, 0, 0, r, s, l);
    check("two_tap", r, 17);

    // ORDER=5: non power-of-two wrap and out-of-range addresses
    sel = 2;
    do_reset();
    for (int k = 0; k < 5; k++) wr(k, k + 1);
    for (int k = 5; k < 8; k++) wr(k, 100);
    samp("c_imp0", 1, 1, 0, 6);
    for (int k = 1; k < 6; k++) samp($sformatf("c_imp%0d", k), 0, (k < 5) ? k + 1 : 0, 0, 6);

    // Defaults: rounding at SHIFT=15
    sel = 1;
    do_reset();
    wr(0, 1);
    samp("rnd_p16384", 16384, 1, 0, 9);
    samp("rnd_p16383", 16383, 0, 0, 9);
    samp("rnd_m16384", -16384, 0, 0, 9);
    samp("rnd_m16385", -16385, -1, 0, 9);

    // Saturation both directions, then hold
    for (int k = 0; k < 8; k++) wr(k, 32767);
    for (int i = 0; i < 8; i++) run_sample(8388607, 1'b0, 1'b0, 0, 0, r, s, l);
    check("satp_result", r, 8388607);
    check("satp_sat", s, 1);
    for (int i = 0; i < 8; i++) run_sample(-8388608, 1'b0, 1'b0, 0, 0, r, s, l);
    check("satn_result", r, -8388608);
    check("satn_sat", s, 1);
    repeat (5) @(posedge clk);
    #1;
    check("hold_result", cur_res, -8388608);
    check("hold_sat", cur_sat, 1);
    do_reset();
    samp("after_rst", 0, 0, 0, 9);

    // Reset in the middle of MAC
    sel = 0;
    do_reset();
    for (int k = 0; k < 8; k++) wr(k, k + 1);
    run_sample(1, 1'b0, 1'b0, 0, 0, r, s, l);
    check("pre_abort", r, 1);
    @(negedge clk); sample = 24'sd1; valid = 1'b1;
    @(posedge clk); #1; valid = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    #1;
    check("abort_ready", cur_ready, 1);
    check("abort_result", cur_res, 0);
    check("abort_valid", cur_valid, 0);
    @(negedge clk); rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; if (cur_valid) cnt++; end
    check("abort_no_valid", cnt, 0);
    samp("clr_imp0", 1, 0, 0, 9);
    for (int k = 1; k < 8; k++) samp($sformatf("clr_imp%0d", k), 0, 0, 0, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
